soc_mem_router: RTL and testbench
=================================

// Module: soc_mem_router
// PURPOSE
// - Parametrised N-slave data-bus router between the rv32i_core data port and SoC targets (SPI RAM ctl, UART, future peripherals).
// - Replaces fixed address decode inside the memory controller: base/mask windows per slave, registered request, one-cycle response pulse.
// - Adds decode-error reporting, saturating error counter, optional access timeout.
// PARAMETERS
// - NUM_SLAVES      4                   number of slave ports (1..16)
// - DATA_W          32                  data width
// - ADDR_W          32                  address width
// - SLV_BASE        {NUM_SLAVES*ADDR_W} packed base per slave; slave i at [i*ADDR_W +: ADDR_W]
// - SLV_MASK        {NUM_SLAVES*ADDR_W} packed mask per slave; hit when (addr & MASK_i) == BASE_i
// - TIMEOUT_CYCLES  255                 ACCESS cycles before forced error (timeout build only), >=1
// - ERR_DATA        32'hDEADBEEF        m_rdata value returned on any error
// PORTS
// - clk       in   1                   clock
// - rst       in   1                   synchronous active-high reset
// - m_addr    in   ADDR_W              core address
// - m_wdata   in   DATA_W              core write data
// - m_flag    in   3                   core size/sign flag, forwarded unchanged
// - m_we      in   1                   write request, held until m_ready
// - m_re      in   1                   read request, held until m_ready
// - m_rdata   out  DATA_W              read data, valid with m_ready
// - m_ready   out  1                   one-cycle completion pulse
// - m_err     out  1                   error qualifier, valid with m_ready
// - err_cnt   out  8                   saturating count of error responses
// - s_sel     out  NUM_SLAVES          one-hot slave select
// - s_addr / s_wdata / s_flag  out  ADDR_W/DATA_W/3  latched request fields
// - s_we, s_re  out  1                 latched direction, asserted only while s_sel != 0
// - s_rdata   in   NUM_SLAVES*DATA_W   packed slave read data
// - s_ready   in   NUM_SLAVES          slave completion, sampled only for selected slave
// BEHAVIOUR
// - Clock clk; reset rst, synchronous, active-high. All outputs registered.
// - Reset: state IDLE; m_ready=0, m_err=0, m_rdata=0, err_cnt=0, s_sel=0, s_we=s_re=0, s_addr/s_wdata/s_flag=0.
// - Reset mid-transaction aborts: s_sel drops next edge, no m_ready issued.
// - FSM IDLE -> ACCESS -> RESP -> IDLE; decode error IDLE -> RESP directly.
// - IDLE: if m_we|m_re, latch addr/wdata/flag/dir, decode; lowest-index hit wins on overlap.
// - m_we&m_re together, or no hit -> decode error: no slave touched.
// - ACCESS: s_sel one-hot, s_we/s_re held; when s_ready[sel]=1, capture s_rdata[sel] (reads) or 0 (writes), go RESP.
// - RESP: m_ready=1 exactly one cycle with m_rdata/m_err; s_sel=0; next IDLE.
// - Latency: slave ready in first ACCESS cycle -> m_ready 2 cycles after request seen; decode error -> 1 cycle.
// - Master drops request the cycle after m_ready; a request seen in IDLE is always new.
// - Error response: m_err=1, m_rdata=ERR_DATA; err_cnt += 1, saturates at 8'hFF.
// - s_ready of unselected slaves, and any s_ready in IDLE/RESP, ignored.
// CONFIGURATION
// - SOC_ROUTER_TIMEOUT_EN defined: cycle counter cleared on entering ACCESS.
//   After TIMEOUT_CYCLES ACCESS cycles without s_ready[sel]: s_sel drops, RESP with m_err=1, m_rdata=ERR_DATA, err_cnt increments.
//   s_ready arriving on the timeout cycle wins (normal response).
// - Undefined: no counter; ACCESS waits indefinitely; only decode errors raise m_err.
// TESTING
// - NUM_SLAVES=2, BASE0=0x0000_0000/MASK0=0xF000_0000; read 0x0000_0010, s_ready[0] same cycle, s_rdata0=0x1234_5678
//   -> m_ready 2 cycles after m_re, m_rdata=0x1234_5678, m_err=0.
// - Write 0x1000_0004 data 0xA5 with BASE1=0x1000_0000, s_ready[1] after 3 cycles
//   -> s_sel=2'b10, s_we=1, s_wdata=0xA5 throughout; m_ready one cycle; m_rdata=0.
// - Read unmapped 0x7000_0000 -> s_sel stays 0, m_ready 1 cycle later, m_err=1, m_rdata=0xDEADBEEF, err_cnt=1.
// - Overlapping windows (both match 0x0) -> slave 0 selected.
// - m_we&m_re=1 -> decode error, no s_sel.
// - 256 decode errors -> err_cnt holds 0xFF.
// - Timeout build, TIMEOUT_CYCLES=4, slave never ready -> s_sel drops after 4 ACCESS cycles, m_err=1, ERR_DATA;
//   non-timeout build -> no m_ready after 1000 cycles.
// - rst pulsed during ACCESS -> next cycle s_sel=0, m_ready never pulses; next request serviced normally.

Source files
------------

// File: rtl/soc_mem_router.sv
// Parametrised N-slave data-bus router with base/mask decode, decode-error reporting and a saturating error counter.
// Optional access timeout is compiled in when SOC_ROUTER_TIMEOUT_EN is defined.
module soc_mem_router #(
    parameter int                           NUM_SLAVES     = 4,
    parameter int                           DATA_W         = 32,
    parameter int                           ADDR_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE       = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK       = '0,
    parameter int                           TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0]            ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [2:0]                   m_flag,
    input  logic                         m_we,
    input  logic                         m_re,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_ready,
    output logic                         m_err,
    output logic [7:0]                   err_cnt,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [2:0]                   s_flag,
    output logic                         s_we,
    output logic                         s_re,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_SLAVES-1:0] hit_oh;
    logic                  req;
    logic                  dec_err;
    logic                  sel_ready;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  tmo_hit;

    // Scan from the top so the lowest-index matching window is the one left standing.
    always_comb begin
        hit_oh = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit_oh = NUM_SLAVES'(1) << i;
            end
        end
    end

    assign req     = m_we | m_re;
    assign dec_err = (m_we & m_re) | ~(|hit_oh);

    // Only the selected slave's ready and data are visible; s_sel is zero outside ACCESS.
    assign sel_ready = |(s_ready & s_sel);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_sel[i]) begin
                sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef SOC_ROUTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != ACCESS) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == ACCESS) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A slave ready on the timeout cycle takes priority over the timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = dec_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (sel_ready || tmo_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_rdata <= '0;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            err_cnt <= '0;
            s_sel   <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_flag  <= '0;
            s_we    <= 1'b0;
            s_re    <= 1'b0;
        end else begin
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_flag  <= m_flag;
                        if (dec_err) begin
                            m_ready <= 1'b1;
                            m_err   <= 1'b1;
                            m_rdata <= ERR_DATA;
                            err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                        end else begin
                            s_sel <= hit_oh;
                            s_we  <= m_we;
                            s_re  <= m_re;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        m_ready <= 1'b1;
                        m_rdata <= s_re ? sel_rdata : '0;
                        s_sel   <= '0;
                        s_we    <= 1'b0;
                        s_re    <= 1'b0;
                    end else if (tmo_hit) begin
                        m_ready <= 1'b1;
                        m_err   <= 1'b1;
                        m_rdata <= ERR_DATA;
                        err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                        s_sel   <= '0;
                        s_we    <= 1'b0;
                        s_re    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_mem_router.sv
// Scoreboard bench for soc_mem_router: three slaves (slave 2 overlaps slave 0), directed vectors.
// Builds with or without SOC_ROUTER_TIMEOUT_EN; the hang/timeout case adapts to the build.
module tb_soc_mem_router;

    localparam int NS = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [31:0]     m_addr;
    logic [31:0]     m_wdata;
    logic [2:0]      m_flag;
    logic            m_we;
    logic            m_re;
    logic [31:0]     m_rdata;
    logic            m_ready;
    logic            m_err;
    logic [7:0]      err_cnt;
    logic [NS-1:0]   s_sel;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic [2:0]      s_flag;
    logic            s_we;
    logic            s_re;
    logic [NS*32-1:0] s_rdata;
    logic [NS-1:0]   s_ready;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   rsp_delay;
    int   acc_cnt;
    int   lat;

    soc_mem_router #(
        .NUM_SLAVES    (NS),
        .DATA_W        (32),
        .ADDR_W        (32),
        .SLV_BASE      ({32'h0000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK      ({32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT_CYCLES(4),
        .ERR_DATA      (32'hDEADBEEF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_flag (m_flag),
        .m_we   (m_we),
        .m_re   (m_re),
        .m_rdata(m_rdata),
        .m_ready(m_ready),
        .m_err  (m_err),
        .err_cnt(err_cnt),
        .s_sel  (s_sel),
        .s_addr (s_addr),
        .s_wdata(s_wdata),
        .s_flag (s_flag),
        .s_we   (s_we),
        .s_re   (s_re),
        .s_rdata(s_rdata),
        .s_ready(s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Slave model: selected slave answers after rsp_delay ACCESS cycles; every unselected
    // slave (and all slaves outside ACCESS) holds ready high to prove those are ignored.
    initial begin
        s_ready = '0;
        acc_cnt = 0;
        forever begin
            @(negedge clk);
            if (s_sel != '0) begin
                s_ready = (acc_cnt == rsp_delay) ? s_sel : ~s_sel;
                acc_cnt++;
            end else begin
                s_ready = '1;
                acc_cnt = 0;
            end
        end
    end

    // Monitor: every m_ready pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_m_ready", 32'(m_ready), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("m_rdata", m_rdata, e.rdata);
                    checkOutput("m_err", 32'(m_err), 32'(e.err));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic we, input logic re, input int delay,
                                 input logic [NS-1:0] exp_sel, input logic [31:0] exp_rdata,
                                 input logic exp_err, input int exp_lat);
        exp_t e;
        int   n;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        rsp_delay = delay;
        @(negedge clk);
        m_addr  = addr;
        m_wdata = wdata;
        m_flag  = 3'b101;
        m_we    = we;
        m_re    = re;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (m_ready !== 1'b1 && n < 50) begin
                checkOutput("s_sel", 32'(s_sel), 32'(exp_sel));
                checkOutput("s_dir", {30'd0, s_we, s_re}, {30'd0, we, re});
                checkOutput("s_addr", s_addr, addr);
                checkOutput("s_wdata", s_wdata, wdata);
                checkOutput("s_flag", 32'(s_flag), 32'd5);
            end
        end while (m_ready !== 1'b1 && n < 50);
        checkOutput("latency", 32'(n), 32'(exp_lat));
        if (m_ready === 1'b1) begin
            checkOutput("resp_s_sel", 32'(s_sel), 32'd0);
        end
        lat = n;
        m_we = 1'b0;
        m_re = 1'b0;
    endtask

    initial begin
        int pulses;
        checks    = 0;
        errors    = 0;
        rsp_delay = 0;
        lat       = 0;
        rst       = 1'b1;
        m_addr    = '0;
        m_wdata   = '0;
        m_flag    = '0;
        m_we      = 1'b0;
        m_re      = 1'b0;
        s_rdata   = {32'h2222_2222, 32'h5555_AAAA, 32'h1234_5678};

        repeat (3) @(negedge clk);
        checkOutput("rst_m_ready", 32'(m_ready), 32'd0);
        checkOutput("rst_m_err", 32'(m_err), 32'd0);
        checkOutput("rst_m_rdata", m_rdata, 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_s_sel", 32'(s_sel), 32'd0);
        checkOutput("rst_s_dir", {30'd0, s_we, s_re}, 32'd0);
        checkOutput("rst_s_addr", s_addr, 32'd0);
        rst = 1'b0;

        applyStimulus(32'h0000_0010, 32'h0, 1'b0, 1'b1, 0, 3'b001, 32'h1234_5678, 1'b0, 2);
        applyStimulus(32'h1000_0004, 32'hA5, 1'b1, 1'b0, 3, 3'b010, 32'h0, 1'b0, 5);
        applyStimulus(32'h1000_0008, 32'h0, 1'b0, 1'b1, 1, 3'b010, 32'h5555_AAAA, 1'b0, 3);
        applyStimulus(32'h7000_0000, 32'h0, 1'b0, 1'b1, 0, 3'b000, 32'hDEAD_BEEF, 1'b1, 1);
        checkOutput("err_cnt_1", 32'(err_cnt), 32'd1);
        applyStimulus(32'h0000_0000, 32'h0, 1'b0, 1'b1, 0, 3'b001, 32'h1234_5678, 1'b0, 2);
        applyStimulus(32'h0000_0010, 32'h77, 1'b1, 1'b1, 0, 3'b000, 32'hDEAD_BEEF, 1'b1, 1);
        checkOutput("err_cnt_2", 32'(err_cnt), 32'd2);

        for (int i = 0; i < 253; i++) begin
            applyStimulus(32'h7000_0000, 32'h0, 1'b0, 1'b1, 0, 3'b000, 32'hDEAD_BEEF, 1'b1, 1);
        end
        checkOutput("err_cnt_255", 32'(err_cnt), 32'hFF);
        applyStimulus(32'h8000_0000, 32'h0, 1'b1, 1'b0, 0, 3'b000, 32'hDEAD_BEEF, 1'b1, 1);
        checkOutput("err_cnt_sat", 32'(err_cnt), 32'hFF);

`ifdef SOC_ROUTER_TIMEOUT_EN
        applyStimulus(32'h1000_0000, 32'h0, 1'b0, 1'b1, -1, 3'b010, 32'hDEAD_BEEF, 1'b1, 5);
        checkOutput("err_cnt_tmo", 32'(err_cnt), 32'hFF);
`endif

        // Unanswered read, then synchronous reset while the access is still open.
        rsp_delay = -1;
        @(negedge clk);
        m_addr = 32'h1000_0000;
        m_re   = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("hang_s_sel", 32'(s_sel), 32'b010);
`ifndef SOC_ROUTER_TIMEOUT_EN
        pulses = 0;
        repeat (1000) begin
            @(negedge clk);
            if (m_ready === 1'b1) pulses++;
        end
        checkOutput("hang_no_ready", 32'(pulses), 32'd0);
        checkOutput("hang_s_sel_held", 32'(s_sel), 32'b010);
`endif
        rst  = 1'b1;
        m_re = 1'b0;
        @(negedge clk);
        checkOutput("abort_s_sel", 32'(s_sel), 32'd0);
        checkOutput("abort_m_ready", 32'(m_ready), 32'd0);
        checkOutput("abort_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        applyStimulus(32'h0000_0020, 32'h0, 1'b0, 1'b1, 0, 3'b001, 32'h1234_5678, 1'b0, 2);
        checkOutput("post_rst_err_cnt", 32'(err_cnt), 32'd0);

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
